// File: rtl/coeff_token_sched_pkg.sv
// coeff_token_sched_pkg: shared FSM states, ROM-select codes and constants for CAVLC coeff_token decode
package coeff_token_sched_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOOKUP = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;
  localparam logic [2:0] RS_NC0 = 3'd0;
  localparam logic [2:0] RS_NC2 = 3'd1;
  localparam logic [2:0] RS_NC4 = 3'd2;
  localparam logic [2:0] RS_NC8 = 3'd3;
  localparam logic [2:0] RS_CDC = 3'd4;
  localparam logic [4:0] COEFF_INVALID = 5'd31;
  localparam logic signed [5:0] NC_CHROMA_DC = -6'sd1;
  typedef struct packed {
    logic [4:0] total_coeff;
    logic [1:0] trailing_ones;
    logic [4:0] num_shift;
  } rom_res_t;
endpackage

// File: rtl/coeff_token_sched_if.sv
// coeff_token_sched_if: request, bitstream, ROM and result signals of the coeff_token scheduler
// slave = scheduler view, master = surrounding environment view
interface coeff_token_sched_if #(parameter int ADDR_W = 16, parameter int CNT_W = 16);
  logic              start;
  logic signed [5:0] nc;
  logic              busy;
  logic              bits_valid;
  logic [ADDR_W-1:0] bits;
  logic              shift_en;
  logic [4:0]        shift_amt;
  logic              shift_ack;
  logic [2:0]        rom_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [4:0]        rom_total_coeff;
  logic [1:0]        rom_trailing_ones;
  logic [4:0]        rom_num_shift;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        total_coeff;
  logic [1:0]        trailing_ones;
  logic              error;
  logic [CNT_W-1:0]  token_count;
  modport slave (
    input  start, nc, bits_valid, bits, shift_ack, rom_total_coeff, rom_trailing_ones, rom_num_shift, out_ready,
    output busy, shift_en, shift_amt, rom_sel, rom_addr, out_valid, total_coeff, trailing_ones, error, token_count
  );
  modport master (
    output start, nc, bits_valid, bits, shift_ack, rom_total_coeff, rom_trailing_ones, rom_num_shift, out_ready,
    input  busy, shift_en, shift_amt, rom_sel, rom_addr, out_valid, total_coeff, trailing_ones, error, token_count
  );
endinterface

// File: rtl/coeff_token_sched_nc_table_sel.sv
// coeff_token_sched_nc_table_sel: maps signed nC to a coeff_token ROM select and flags nC < -1
// nc in, rom_sel out (0..4), illegal out
module coeff_token_sched_nc_table_sel
  import coeff_token_sched_pkg::*;
(
  input  logic signed [5:0] nc,
  output logic [2:0]        rom_sel,
  output logic              illegal
);
  assign rom_sel = nc == NC_CHROMA_DC ? RS_CDC :
                   nc < 6'sd2         ? RS_NC0 :
                   nc < 6'sd4         ? RS_NC2 :
                   nc < 6'sd8         ? RS_NC4 : RS_NC8;
  assign illegal = nc < NC_CHROMA_DC;
endmodule

// File: rtl/coeff_token_sched.sv
// coeff_token_sched: sequences one CAVLC coeff_token decode per start (fetch, ROM lookup, shift, output)
// clk, reset: clock and synchronous active-high reset
// bus (slave): start/nc request, bits window, shifter handshake, ROM bank, result handshake, status
module coeff_token_sched
  import coeff_token_sched_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  coeff_token_sched_if.slave   bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [2:0]    state;
  logic [2:0]    sel_q;
  logic [2:0]    sel_d;
  logic          illegal;
  rom_res_t      res;
  logic [TW-1:0] wait_cnt;
  coeff_token_sched_nc_table_sel u_sel (.nc(bus.nc), .rom_sel(sel_d), .illegal(illegal));
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      sel_q          <= '0;
      bus.rom_addr   <= '0;
      res            <= '0;
      wait_cnt       <= '0;
      bus.token_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          sel_q <= sel_d;
          state <= illegal ? S_ERR : S_FETCH;
        end
        S_FETCH: if (bus.bits_valid) begin
          bus.rom_addr <= bus.bits;
          state        <= S_LOOKUP;
        end
        S_LOOKUP: begin
          res      <= '{bus.rom_total_coeff, bus.rom_trailing_ones, bus.rom_num_shift};
          wait_cnt <= '0;
          state    <= (bus.rom_total_coeff == COEFF_INVALID || bus.rom_num_shift == 5'd0) ? S_ERR : S_SHIFT;
        end
        // ack on the last permitted cycle still wins over the timeout
        S_SHIFT: if (bus.shift_ack) state <= S_OUT;
          else if (wait_cnt == TW'(ACK_TIMEOUT - 1)) state <= S_ERR;
          else wait_cnt <= wait_cnt + 1'b1;
        S_OUT: if (bus.out_ready) begin
          bus.token_count <= bus.token_count + 1'b1;
          state           <= S_IDLE;
        end
        default: ;
      endcase
    end
  end
  assign bus.busy          = state != S_IDLE;
  assign bus.shift_en      = state == S_SHIFT;
  assign bus.out_valid     = state == S_OUT;
  assign bus.error         = state == S_ERR;
  assign bus.rom_sel       = sel_q;
  assign bus.shift_amt     = res.num_shift;
  assign bus.total_coeff   = res.total_coeff;
  assign bus.trailing_ones = res.trailing_ones;
endmodule

// File: tb/tb_coeff_token_sched.sv
// tb_coeff_token_sched: randomized self-checking bench for coeff_token_sched against a transaction-level model
module tb_coeff_token_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [3:0] exp_cnt = '0;
  logic [15:0] t_bits;
  logic [2:0] t_sel;
  logic [4:0] t_tc, t_ns;
  logic [1:0] t_t1;
  coeff_token_sched_if #(.ADDR_W(16), .CNT_W(4)) bus ();
  coeff_token_sched #(.ACK_TIMEOUT(255)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // ROM stub answers only the expected table/address, anything else reads as no-match
  assign bus.rom_total_coeff   = (bus.rom_addr == t_bits && bus.rom_sel == t_sel) ? t_tc : 5'd31;
  assign bus.rom_num_shift     = (bus.rom_addr == t_bits && bus.rom_sel == t_sel) ? t_ns : 5'd0;
  assign bus.rom_trailing_ones = t_t1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
  endtask
  function automatic logic [2:0] ref_sel(input int nc);
    if (nc == -1) return 3'd4;
    if (nc >= 8) return 3'd3;
    if (nc >= 4) return 3'd2;
    if (nc >= 2) return 3'd1;
    return 3'd0;
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
    check("rst_busy", bus.busy, 0);
    check("rst_error", bus.error, 0);
    check("rst_outs", {bus.shift_en, bus.out_valid}, 0);
    check("rst_tok", bus.token_count, 0);
  endtask
  task automatic txn(input int nc, input logic [15:0] b, input int tc, input int t1, input int ns,
                     input int bvd, input int ackd, input int rdyd, input bit rst_shift);
    int st;
    t_bits = b;
    t_sel = ref_sel(nc);
    t_tc = 5'(tc);
    t_t1 = 2'(t1);
    t_ns = 5'(ns);
    bus.shift_ack = 1'($urandom);
    bus.start = 1'b1;
    bus.nc = 6'(nc);
    st = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.shift_ack = 1'b0;
    if (nc < -1) begin
      check("ill_error", bus.error, 1);
      check("ill_busy", bus.busy, 1);
      repeat (3) begin
        bus.start = 1'b1;
        bus.nc = 6'd3;
        @(negedge clk);
        check("ill_sticky", {bus.error, bus.shift_en, bus.out_valid}, 3'b100);
      end
      bus.start = 1'b0;
      do_reset();
      return;
    end
    check("start_busy", bus.busy, 1);
    check("rom_sel", bus.rom_sel, t_sel);
    repeat (bvd) begin
      bus.start = 1'($urandom);
      bus.nc = 6'($urandom);
      bus.bits = 16'($urandom);
      @(negedge clk);
      check("fetch_wait", {bus.shift_en, bus.out_valid, bus.busy}, 3'b001);
    end
    bus.start = 1'b0;
    bus.bits_valid = 1'b1;
    bus.bits = b;
    @(negedge clk);
    bus.bits_valid = 1'b0;
    bus.bits = 16'($urandom);
    check("rom_addr", bus.rom_addr, b);
    check("sel_hold", bus.rom_sel, t_sel);
    @(negedge clk);
    if (tc == 31 || ns == 0) begin
      check("nomatch_err", {bus.error, bus.shift_en, bus.out_valid}, 3'b100);
      repeat (2) @(negedge clk);
      check("nomatch_sticky", {bus.error, bus.shift_en}, 2'b10);
      do_reset();
      return;
    end
    check("shift_en", bus.shift_en, 1);
    check("shift_amt", bus.shift_amt, ns);
    if (rst_shift) begin
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_cnt = '0;
      check("midrst", {bus.shift_en, bus.out_valid, bus.busy, bus.error}, 0);
      check("midrst_tok", bus.token_count, 0);
      return;
    end
    for (int i = 0; i < ackd && i < 255; i++) begin
      check("shift_hold", {bus.shift_en, bus.shift_amt}, {1'b1, 5'(ns)});
      bus.out_ready = 1'($urandom);
      bus.bits_valid = 1'($urandom);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    bus.bits_valid = 1'b0;
    if (ackd >= 255) begin
      check("timeout_err", {bus.error, bus.shift_en, bus.out_valid}, 3'b100);
      do_reset();
      return;
    end
    bus.shift_ack = 1'b1;
    @(negedge clk);
    bus.shift_ack = 1'b0;
    check("latency", cyc - st, 4 + bvd + ackd);
    check("out_valid", {bus.out_valid, bus.shift_en}, 2'b10);
    check("out_data", {bus.total_coeff, bus.trailing_ones}, {5'(tc), 2'(t1)});
    repeat (rdyd) begin
      bus.shift_ack = 1'($urandom);
      @(negedge clk);
      check("out_hold", {bus.out_valid, bus.total_coeff, bus.trailing_ones}, {1'b1, 5'(tc), 2'(t1)});
    end
    bus.shift_ack = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    check("tok", bus.token_count, exp_cnt);
    check("idle", {bus.busy, bus.out_valid}, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.nc = '0;
    bus.bits_valid = 1'b0;
    bus.bits = '0;
    bus.shift_ack = 1'b0;
    bus.out_ready = 1'b0;
    t_bits = '0;
    t_sel = '0;
    t_tc = '0;
    t_t1 = '0;
    t_ns = '0;
    repeat (2) @(negedge clk);
    check("rst_state", {bus.busy, bus.shift_en, bus.out_valid, bus.error}, 0);
    check("rst_regs", {bus.rom_sel, bus.rom_addr, bus.shift_amt, bus.token_count}, 0);
    reset = 1'b0;
    @(negedge clk);
    txn(9, 16'h0C00, 0, 0, 6, 0, 0, 0, 0);
    txn(12, 16'hFC00, 16, 3, 6, 0, 0, 3, 0);
    txn(-1, 16'h8000, 1, 1, 1, 1, 1, 1, 0);
    txn(-2, 16'h1234, 1, 0, 2, 0, 0, 0, 0);
    txn(5, 16'h0001, 31, 0, 0, 0, 0, 0, 0);
    txn(3, 16'h4000, 2, 1, 4, 0, 255, 0, 0);
    txn(3, 16'h4000, 2, 1, 4, 0, 10, 0, 0);
    txn(0, 16'h2A00, 4, 2, 7, 0, 254, 0, 0);
    txn(1, 16'h3300, 3, 3, 5, 0, 0, 0, 1);
    txn(1, 16'h3300, 3, 3, 5, 0, 0, 0, 0);
    for (int k = 0; k < 60; k++) begin
      int nc, r, ackd, tc, ns;
      nc = $urandom_range(23) - 3;
      r = $urandom_range(9);
      ackd = r == 0 ? 255 + $urandom_range(2) : r == 1 ? 254 : $urandom_range(11);
      tc = ($urandom_range(9) == 0) ? 31 : $urandom_range(16);
      ns = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 16);
      txn(nc, 16'($urandom), tc, $urandom_range(3), ns, $urandom_range(3), ackd,
          $urandom_range(4), $urandom_range(14) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
